// File: rtl/spi_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_reg_pkg
//  Purpose  : Shared constants, FSM state codes and SPI mode helpers for the
//             SPI burst register-access port.
//  Revision : 1.0 - initial release
// ============================================================================
package spi_reg_pkg;

    localparam int BYTE_W     = 8;
    localparam int CMD_RW_BIT = 7;

    // Bit positions inside the {CPOL,CPHA} mode field
    localparam int MODE_CPOL_IDX = 1;
    localparam int MODE_CPHA_IDX = 0;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CMD     = 2'd1;
    localparam logic [1:0] ST_WR_DATA = 2'd2;
    localparam logic [1:0] ST_RD_DATA = 2'd3;

    // Data is sampled on the rising SPI clock edge when CPOL equals CPHA,
    // otherwise on the falling edge.
    function automatic logic sample_on_rise(input logic [1:0] mode);
        return mode[MODE_CPOL_IDX] == mode[MODE_CPHA_IDX];
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module   : spi_edge_sync
//  Purpose  : Conditions one SPI pin: optional 2-flop synchroniser (enabled by
//             the SPI_REG_BURST_SYNC_EN macro), one history flop and 1-clk
//             rise/fall pulses. All flops hold while ena is low.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic prev;

`ifdef SPI_REG_BURST_SYNC_EN
    logic [1:0] sync_ff;

    // Two-stage synchroniser for a pin asynchronous to clk
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= 2'b00;
        end else if (ena) begin
            sync_ff <= {sync_ff[0], pin};
        end
    end

    assign level = sync_ff[1];
`else
    // Pin is already synchronous to clk; the history flop is the only register
    assign level = pin;
`endif

    // History flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
        end else if (ena) begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;

endmodule
`default_nettype wire

// File: rtl/spi_reg_burst.sv
`default_nettype none
// ============================================================================
//  Module   : spi_reg_burst
//  Purpose  : SPI slave register-access port. Command byte {rw, addr} followed
//             by an unlimited burst of data bytes with address auto-increment.
//             All four SPI modes, chosen per frame at CS fall.
//             Build option: define SPI_REG_BURST_SYNC_EN to insert 2-flop
//             synchronisers on spi_clk, spi_cs_n and spi_mosi.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_reg_burst
    import spi_reg_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int REG_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [1:0]        spi_mode,
    input  logic              spi_clk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [REG_W-1:0]  reg_data_o,
    output logic              reg_wr_stb,
    output logic              reg_rd_stb,
    input  logic [REG_W-1:0]  reg_data_i,
    output logic              frame_err
);

    generate
        if (REG_W != BYTE_W) begin : g_bad_reg_w
            $error("spi_reg_burst: REG_W must be 8");
        end
        if ((ADDR_W < 1) || (ADDR_W > 7)) begin : g_bad_addr_w
            $error("spi_reg_burst: ADDR_W must be in 1..7");
        end
    endgenerate

    localparam logic [2:0]        LAST_BIT = 3'(BYTE_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    // Conditioned pins
    logic sclk_level_unused;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_n_level;
    logic cs_rise;
    logic cs_fall;
    logic mosi_level;
    logic mosi_rise_unused;
    logic mosi_fall_unused;

    // Frame state
    logic [1:0]        state;
    logic [1:0]        mode;
    logic [2:0]        bit_cnt;
    logic [BYTE_W-1:0] rx_sr;
    logic [BYTE_W-1:0] tx_sr;
    logic [ADDR_W-1:0] addr;
    logic              rd_cap;

    // Decoded per-cycle events
    logic              sample_rise;
    logic              sample_edge;
    logic              change_edge;
    logic              last_bit;
    logic [BYTE_W-1:0] rx_next;

    spi_edge_sync u_sync_clk (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .pin   (spi_clk),
        .level (sclk_level_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_edge_sync u_sync_cs (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .pin   (spi_cs_n),
        .level (cs_n_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_edge_sync u_sync_mosi (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .pin   (spi_mosi),
        .level (mosi_level),
        .rise  (mosi_rise_unused),
        .fall  (mosi_fall_unused)
    );

    // Map SPI clock edges to sample/change events for the latched mode
    always_comb begin
        sample_rise = sample_on_rise(mode);
        sample_edge = 1'b0;
        change_edge = 1'b0;
        if (!cs_n_level) begin
            sample_edge = sample_rise ? sclk_rise : sclk_fall;
            change_edge = sample_rise ? sclk_fall : sclk_rise;
        end
        rx_next  = {rx_sr[BYTE_W-2:0], mosi_level};
        last_bit = (bit_cnt == LAST_BIT);
    end

    // Frame FSM, shift registers, address counter and strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            mode       <= 2'b00;
            bit_cnt    <= 3'd0;
            rx_sr      <= '0;
            tx_sr      <= '0;
            addr       <= '0;
            rd_cap     <= 1'b0;
            reg_data_o <= '0;
            reg_wr_stb <= 1'b0;
            reg_rd_stb <= 1'b0;
            frame_err  <= 1'b0;
        end else if (ena) begin
            reg_wr_stb <= 1'b0;
            reg_rd_stb <= 1'b0;
            frame_err  <= 1'b0;
            rd_cap     <= reg_rd_stb;

            // Register file answers one clk after the read request
            if (rd_cap) begin
                tx_sr <= reg_data_i;
            end

            // Post-increment after a write so the strobe carries the old address
            if (reg_wr_stb) begin
                addr <= addr + ADDR_ONE;
            end

            if (cs_rise) begin
                // A partially shifted byte is dropped without any strobe
                state     <= ST_IDLE;
                bit_cnt   <= 3'd0;
                frame_err <= (bit_cnt != 3'd0);
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            state   <= ST_CMD;
                            mode    <= spi_mode;
                            bit_cnt <= 3'd0;
                            rx_sr   <= '0;
                            tx_sr   <= '0;
                        end
                    end

                    ST_CMD: begin
                        if (sample_edge) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            rx_sr   <= rx_next;
                            if (last_bit) begin
                                addr <= rx_next[ADDR_W-1:0];
                                if (rx_next[CMD_RW_BIT]) begin
                                    state <= ST_WR_DATA;
                                end else begin
                                    state      <= ST_RD_DATA;
                                    reg_rd_stb <= 1'b1;
                                end
                            end
                        end
                    end

                    ST_WR_DATA: begin
                        if (sample_edge) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            rx_sr   <= rx_next;
                            if (last_bit) begin
                                reg_wr_stb <= 1'b1;
                                reg_data_o <= rx_next;
                            end
                        end
                    end

                    ST_RD_DATA: begin
                        if (sample_edge) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            rx_sr   <= rx_next;
                            if (last_bit) begin
                                // Advance and prefetch the next byte of the burst
                                addr       <= addr + ADDR_ONE;
                                reg_rd_stb <= 1'b1;
                            end
                        end
                        // No shift before the first sample of a byte, so bit 7
                        // stays on the line in both CPHA settings
                        if (change_edge && (bit_cnt != 3'd0)) begin
                            tx_sr <= {tx_sr[BYTE_W-2:0], 1'b0};
                        end
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign reg_addr = addr;
    assign spi_miso = (state == ST_RD_DATA) & tx_sr[BYTE_W-1];

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_burst.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_reg_burst
//  Purpose  : Self-checking bench for spi_reg_burst: bit-banged SPI master,
//             register-file model and a frame-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_reg_burst;

    localparam int H = 4;   // SPI half-period in clk cycles

    logic       clk;
    logic       rst;
    logic       ena;
    logic [1:0] spi_mode;
    logic       spi_clk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic [6:0] reg_addr;
    logic [7:0] reg_data_o;
    logic       reg_wr_stb;
    logic       reg_rd_stb;
    logic [7:0] reg_data_i;
    logic       frame_err;

    spi_reg_burst #(.ADDR_W(7), .REG_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .spi_mode   (spi_mode),
        .spi_clk    (spi_clk),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .reg_addr   (reg_addr),
        .reg_data_o (reg_data_o),
        .reg_wr_stb (reg_wr_stb),
        .reg_rd_stb (reg_rd_stb),
        .reg_data_i (reg_data_i),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Register file seen by the DUT
    logic [7:0] mem     [0:127];
    logic [7:0] preload [0:127];
    logic       load_mem;

    always @(posedge clk) begin
        if (load_mem) begin
            mem <= preload;
        end else begin
            if (reg_wr_stb) mem[reg_addr] <= reg_data_o;
            if (reg_rd_stb) reg_data_i <= mem[reg_addr];
        end
    end

    // Observed strobe activity
    logic [14:0] wr_log[$];
    logic [6:0]  rd_log[$];
    int          fe_cnt;

    always @(negedge clk) begin
        if (reg_wr_stb) wr_log.push_back({reg_addr, reg_data_o});
        if (reg_rd_stb) rd_log.push_back(reg_addr);
        if (frame_err)  fe_cnt++;
    end

    // Reference model state
    logic [7:0]  exp_mem [0:127];
    logic [14:0] exp_wr[$];
    logic [1:0]  cur_mode;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs;
        wr_log.delete();
        rd_log.delete();
        exp_wr.delete();
        fe_cnt = 0;
    endtask

    task automatic do_preload;
        load_mem = 1'b1;
        @(negedge clk);
        load_mem = 1'b0;
        exp_mem = preload;
    endtask

    task automatic cs_start(input logic [1:0] m);
        cur_mode = m;
        spi_mode = m;
        spi_clk  = m[1];
        spi_mosi = 1'b0;
        repeat (H) @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (H) @(negedge clk);
        spi_mode = 2'($urandom);     // later changes must be ignored
    endtask

    task automatic cs_end;
        repeat (H) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (H + 2) @(negedge clk);
    endtask

    // Shift nbits of tx MSB-first, returning the MISO bits seen at sample edges
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!cur_mode[0]) begin
                spi_mosi = tx[i];
                repeat (H) @(negedge clk);
                rx[i]   = spi_miso;
                spi_clk = ~spi_clk;
                repeat (H) @(negedge clk);
                spi_clk = ~spi_clk;
            end else begin
                spi_clk  = ~spi_clk;
                spi_mosi = tx[i];
                repeat (H) @(negedge clk);
                rx[i]   = spi_miso;
                spi_clk = ~spi_clk;
                repeat (H) @(negedge clk);
            end
        end
    endtask

    task automatic check_writes(input string tag);
        chk($sformatf("%s_wr_count", tag), wr_log.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size(); i++) begin
            if (i < wr_log.size())
                chk($sformatf("%s_wr%0d", tag, i), wr_log[i], exp_wr[i]);
        end
    endtask

    task automatic check_reads(input string tag, input logic [6:0] a, input int n);
        chk($sformatf("%s_rd_count", tag), rd_log.size(), n + 1);
        for (int i = 0; i <= n; i++) begin
            if (i < rd_log.size())
                chk($sformatf("%s_rd_addr%0d", tag, i), rd_log[i], 7'(a + i));
        end
    endtask

    // Write burst frame; the reference model records expected writes
    task automatic wr_frame(input string tag, input logic [1:0] m,
                            input logic [6:0] a, input logic [7:0] d [$]);
        logic [7:0] rx;
        clear_logs();
        cs_start(m);
        xfer({1'b1, a}, 8, rx);
        for (int i = 0; i < d.size(); i++) begin
            xfer(d[i], 8, rx);
            exp_wr.push_back({7'(a + i), d[i]});
            exp_mem[7'(a + i)] = d[i];
        end
        cs_end();
        check_writes(tag);
        chk({tag, "_frame_err"}, fe_cnt, 0);
    endtask

    // Read burst frame; MISO bytes compared against the reference memory
    task automatic rd_frame(input string tag, input logic [1:0] m,
                            input logic [6:0] a, input int n);
        logic [7:0] rx;
        clear_logs();
        cs_start(m);
        xfer({1'b0, a}, 8, rx);
        for (int i = 0; i < n; i++) begin
            xfer(8'($urandom), 8, rx);
            chk($sformatf("%s_miso%0d", tag, i), rx, exp_mem[7'(a + i)]);
        end
        cs_end();
        check_reads(tag, a, n);
        chk({tag, "_frame_err"}, fe_cnt, 0);
    endtask

    initial begin
        logic [7:0] d [$];
        logic [7:0] rx;

        rst      = 1'b1;
        ena      = 1'b1;
        spi_mode = 2'b00;
        spi_clk  = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        load_mem = 1'b0;
        cur_mode = 2'b00;
        fe_cnt   = 0;
        for (int i = 0; i < 128; i++) preload[i] = 8'($urandom);
        do_preload();
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_miso",       spi_miso,   0);
        chk("rst_reg_addr",   reg_addr,   0);
        chk("rst_reg_data_o", reg_data_o, 0);
        chk("rst_wr_stb",     reg_wr_stb, 0);
        chk("rst_rd_stb",     reg_rd_stb, 0);
        chk("rst_frame_err",  frame_err,  0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1. Mode 0 write burst
        d = '{8'hA5, 8'h3C};
        wr_frame("t1", 2'd0, 7'h05, d);
        if (wr_log.size() == 2) begin
            chk("t1_first",  wr_log[0], {7'h05, 8'hA5});
            chk("t1_second", wr_log[1], {7'h06, 8'h3C});
        end

        // 2. Mode 3 read burst from a register file returning addr^0xFF
        for (int i = 0; i < 128; i++) preload[i] = 8'(i) ^ 8'hFF;
        do_preload();
        clear_logs();
        cs_start(2'd3);
        xfer(8'h10, 8, rx);
        xfer(8'h00, 8, rx); chk("t2_byte0", rx, 8'hEF);
        xfer(8'h00, 8, rx); chk("t2_byte1", rx, 8'hEE);
        xfer(8'h00, 8, rx); chk("t2_byte2", rx, 8'hED);
        cs_end();
        check_reads("t2", 7'h10, 3);

        // 3. Modes 1 and 2 read the same register
        preload[2] = 8'h81;
        do_preload();
        rd_frame("t3_mode1", 2'd1, 7'h02, 1);
        rd_frame("t3_mode2", 2'd2, 7'h02, 1);

        // 4. Address wraps from the top register to 0
        d = '{8'h11, 8'h22};
        wr_frame("t4", 2'd0, 7'h7F, d);
        if (wr_log.size() == 2) chk("t4_wrap", wr_log[1], {7'h00, 8'h22});

        // 5. CS rises mid-byte: frame error, no write; next frame is clean
        clear_logs();
        cs_start(2'd0);
        xfer(8'h83, 8, rx);
        xfer(8'hFF, 5, rx);
        cs_end();
        chk("t5_frame_err", fe_cnt, 1);
        chk("t5_no_write",  wr_log.size(), 0);
        d = '{8'h77};
        wr_frame("t5_next", 2'd0, 7'h04, d);

        // 6. Reset in the middle of a read burst
        preload = exp_mem;
        preload[5] = 8'h00;
        preload[6] = 8'hFF;
        do_preload();
        clear_logs();
        cs_start(2'd0);
        xfer(8'h05, 8, rx);
        xfer(8'h00, 8, rx);
        chk("t6_byte0", rx, 8'h00);
        xfer(8'h00, 3, rx);
        chk("t6_pre_miso", spi_miso, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_miso",       spi_miso,   0);
        chk("t6_reg_addr",   reg_addr,   0);
        chk("t6_reg_data_o", reg_data_o, 0);
        chk("t6_wr_stb",     reg_wr_stb, 0);
        chk("t6_rd_stb",     reg_rd_stb, 0);
        chk("t6_frame_err",  frame_err,  0);
        rst = 1'b0;
        spi_clk = cur_mode[1];
        cs_end();
        d = '{8'h55};
        wr_frame("t6_next", 2'd0, 7'h01, d);

        // Randomised frames against the reference model
        for (int f = 0; f < 16; f++) begin
            logic [1:0] m;
            logic [6:0] a;
            int         n;
            m = 2'($urandom);
            a = 7'($urandom);
            n = 1 + int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                d.delete();
                for (int i = 0; i < n; i++) d.push_back(8'($urandom));
                wr_frame($sformatf("rnd%0d_wr", f), m, a, d);
            end else begin
                rd_frame($sformatf("rnd%0d_rd", f), m, a, n);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
